// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose: widths, the NOP encoding, fetch FSM state codes and the FIFO entry
// layout used by if_fetch and if_fetch_fifo.
// Ports: none (package).

package if_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous {pc, inst} buffer between memory and the IF/ID register
//
// Purpose: small power-of-two FIFO holding fetched instructions with their address.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data this cycle
//   push_data   {pc, inst} entry
//   pop         drop the head entry this cycle
//   flush       empty the FIFO; wins over push and pop
//   head        current head entry (valid when count != 0)
//   count       number of stored entries

import if_fetch_pkg::*;

module if_fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       storage [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = storage[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, memory req/gnt/rvalid FSM, instruction buffer
//
// Purpose: owns the fetch PC, issues one word read at a time, buffers returned
// words and presents them to the IF/ID register; holds under stall, redirects on branch.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_i           downstream cannot accept the head instruction
//   branch_en_i       single-cycle redirect pulse
//   branch_target_i   redirect address (low two bits ignored)
//   mem_req_o         read request, held until mem_gnt_i
//   mem_addr_o        word-aligned request address
//   mem_gnt_i         request accepted
//   mem_rvalid_i      read data valid, in order, at least one cycle after grant
//   mem_rdata_i       read data
//   pc_o, inst_o      head instruction and its address (0 / NOP when invalid)
//   inst_valid_o      pc_o/inst_o carry a real fetched instruction

import if_fetch_pkg::*;

module if_fetch #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         branch_en_i,
    input  logic [31:0]  branch_target_i,
    output logic         mem_req_o,
    output logic [31:0]  mem_addr_o,
    input  logic         mem_gnt_i,
    input  logic         mem_rvalid_i,
    input  logic [31:0]  mem_rdata_i,
    output logic [31:0]  pc_o,
    output logic [31:0]  inst_o,
    output logic         inst_valid_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if_state_e          state;
    if_state_e          state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  fetch_pc_next;
    logic [ADDR_W-1:0]  req_addr;
    logic               discard;
    logic               discard_next;

    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after;
    fetch_entry_t       head;
    fetch_entry_t       push_data;
    logic [ADDR_W-1:0]  target;

    assign target = word_align(branch_target_i);

    // A redirect flushes the buffer, so it also suppresses this cycle's push and pop.
    assign push        = (state == IF_WAIT) && mem_rvalid_i && !discard && !branch_en_i;
    assign pop         = inst_valid_o && !stall_i && !branch_en_i;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign push_data   = '{pc: req_addr, inst: mem_rdata_i};

    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (branch_en_i),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        discard_next  = discard;

        case (state)
            IF_IDLE: begin
                // Nothing outstanding here, so a free slot only depends on count.
                if (branch_en_i || (count < CNT_W'(FIFO_DEPTH))) begin
                    state_next = IF_REQ;
                end
            end
            IF_REQ: begin
                if (mem_gnt_i) begin
                    state_next = IF_WAIT;
                    // After an earlier redirect fetch_pc already holds the target.
                    if (!discard) begin
                        fetch_pc_next = fetch_pc + 32'd4;
                    end
                end
                // The request address stays put; its response is dropped instead.
                if (branch_en_i) begin
                    discard_next = 1'b1;
                end
            end
            IF_WAIT: begin
                if (mem_rvalid_i) begin
                    // The single outstanding response is consumed either way.
                    discard_next = 1'b0;
                    if (branch_en_i || (count_after < CNT_W'(FIFO_DEPTH))) begin
                        state_next = IF_REQ;
                    end else begin
                        state_next = IF_IDLE;
                    end
                end else if (branch_en_i) begin
                    discard_next = 1'b1;
                end
            end
            default: begin
                state_next = IF_IDLE;
            end
        endcase

        if (branch_en_i) begin
            fetch_pc_next = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IF_IDLE;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            discard  <= discard_next;
        end
    end

    // The request address is captured when a request starts and frozen until the
    // response returns; it is also the pc tagged onto the pushed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr <= RESET_PC;
        end else if ((state_next == IF_REQ) && (state != IF_REQ)) begin
            req_addr <= fetch_pc_next;
        end
    end

    assign mem_req_o    = (state == IF_REQ);
    assign mem_addr_o   = req_addr;
    assign inst_valid_o = (count != '0);
    assign pc_o         = inst_valid_o ? head.pc   : '0;
    assign inst_o       = inst_valid_o ? head.inst : NOP_INST;

endmodule
